deflect_port_alloc: RTL and testbench

DEFLECT_PORT_ALLOC -- requirements
Module: deflect_port_alloc

---
 rtl/deflect_port_alloc_pkg.sv | 23 ++
 rtl/deflect_port_alloc_port_pick.sv | 35 +++
 rtl/deflect_port_alloc.sv | 182 ++++++++++++++++++
 tb/tb_deflect_port_alloc.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/deflect_port_alloc_pkg.sv
// rtl/deflect_port_alloc_pkg.sv - shared port indices, widths and injection FSM encoding
package deflect_port_alloc_pkg;

    localparam int NUM_PORT = 5;
    localparam int NUM_CH   = 4;

    localparam int WEST  = 0;
    localparam int EAST  = 1;
    localparam int SOUTH = 2;
    localparam int NORTH = 3;
    localparam int LOCAL = 4;

    // Ports usable by any requester; Local is only ever taken productively.
    localparam logic [NUM_PORT-1:0] NET_MASK =
        NUM_PORT'((1 << WEST) | (1 << EAST) | (1 << SOUTH) | (1 << NORTH));

    typedef enum logic [1:0] {
        INJ_IDLE    = 2'd0,
        INJ_WAIT    = 2'd1,
        INJ_STARVED = 2'd2
    } injState_t;

endpackage

// File: rtl/deflect_port_alloc_port_pick.sv
// rtl/deflect_port_alloc_port_pick.sv - picks one output port for one requester
//
// Ports:
//   freeMask  ports still unassigned at this point of the chain
//   prodVec   requester's productive vector (bit 4 = Local)
//   port      one-hot chosen port, zero when nothing is free
//   deflect   chosen port is not productive for this requester
module deflect_port_alloc_port_pick
    import deflect_port_alloc_pkg::*;
(
    input  logic [NUM_PORT-1:0] freeMask,
    input  logic [NUM_PORT-1:0] prodVec,
    output logic [NUM_PORT-1:0] port,
    output logic                deflect
);

    localparam logic [NUM_PORT-1:0] LOCAL_BIT = NUM_PORT'(1) << LOCAL;

    logic [NUM_PORT-1:0] prodFree;
    logic [NUM_PORT-1:0] deflFree;

    always_comb begin
        prodFree = freeMask & prodVec;
        // Local is never a deflection target.
        deflFree = freeMask & ~LOCAL_BIT;
        // x & -x isolates the lowest set bit.
        if (|prodFree) begin
            port = prodFree & (~prodFree + NUM_PORT'(1));
        end else begin
            port = deflFree & (~deflFree + NUM_PORT'(1));
        end
        deflect = (|port) && !(|(port & prodVec));
    end

endmodule

// File: rtl/deflect_port_alloc.sv
// rtl/deflect_port_alloc.sv - deflection router output-port allocator with injection starvation tracking
//
// Optional feature macro: DEFLECT_CNT_EN (adds 16-bit saturating deflectCnt output).
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   validIn[3:0]         flit valid per network channel (W, E, S, N)
//   prodVecIn[19:0]      productive vector per channel, channel i at [5i+4:5i]
//   injReq, injProdVec   local injection request and its productive vector
//   allocOut[24:0]       registered one-hot port per requester (4 = injection)
//   allocValid[4:0]      registered grant-valid per requester
//   deflected[4:0]       registered deflection flag per requester
//   injGnt               registered injection grant
//   injStarve            registered starvation flag
//   deflectCnt[15:0]     (DEFLECT_CNT_EN only) saturating deflection count
module deflect_port_alloc
    import deflect_port_alloc_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          validIn,
    input  logic [NUM_CH*NUM_PORT-1:0] prodVecIn,
    input  logic                       injReq,
    input  logic [NUM_PORT-1:0]        injProdVec,
    output logic [5*NUM_PORT-1:0]      allocOut,
    output logic [4:0]                 allocValid,
    output logic [4:0]                 deflected,
    output logic                       injGnt,
`ifdef DEFLECT_CNT_EN
    output logic                       injStarve,
    output logic [15:0]                deflectCnt
`else
    output logic                       injStarve
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]                     ptr;
    injState_t                      injState;
    logic [3:0]                     denyCnt;
    logic [3:0]                     denyCntNext;

    // Slot j of the service chain is channel ptr+j; slot 4 is injection.
    logic [NUM_CH-1:0]              slotValid;
    logic [NUM_CH-1:0][NUM_PORT-1:0] slotProd;
    logic [4:0][NUM_PORT-1:0]       slotPort;
    logic [4:0]                     slotDefl;
    logic [4:0][NUM_PORT-1:0]       freeChain;

    logic [5*NUM_PORT-1:0]          allocNext;
    logic [4:0]                     validNext;
    logic [4:0]                     deflNext;
    logic                           injGntNext;
    logic                           injDenied;

    assign freeChain[0] = '1;

    for (genvar j = 0; j < NUM_CH; j++) begin : g_slot
        logic [1:0] ch;
        assign ch           = ptr + 2'(j);
        assign slotValid[j] = validIn[ch];
        assign slotProd[j]  = prodVecIn[ch*NUM_PORT +: NUM_PORT];

        deflect_port_alloc_port_pick u_pick (
            .freeMask (freeChain[j]),
            .prodVec  (slotProd[j]),
            .port     (slotPort[j]),
            .deflect  (slotDefl[j])
        );

        assign freeChain[j+1] = freeChain[j] & ~(slotValid[j] ? slotPort[j] : '0);
    end

    // Injection only competes for whatever of ports 0..3 the network left,
    // so its Local bit never matters.
    deflect_port_alloc_port_pick u_pickInj (
        .freeMask (freeChain[4] & NET_MASK),
        .prodVec  (injProdVec),
        .port     (slotPort[4]),
        .deflect  (slotDefl[4])
    );

    // Map slot results back to channel order.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        logic [1:0] slot;
        assign slot                         = 2'(c) - ptr;
        assign allocNext[c*NUM_PORT +: NUM_PORT] = validIn[c] ? slotPort[slot] : '0;
        assign validNext[c]                 = validIn[c];
        assign deflNext[c]                  = validIn[c] & slotDefl[slot];
    end

    assign injGntNext = injReq & (|slotPort[4]);
    assign injDenied  = injReq & ~injGntNext;
    assign allocNext[4*NUM_PORT +: NUM_PORT] = injGntNext ? slotPort[4] : '0;
    assign validNext[4] = injGntNext;
    assign deflNext[4]  = injGntNext & slotDefl[4];

    always_comb begin
        denyCntNext = denyCnt;
        if (!injDenied) begin
            denyCntNext = 4'd0;
        end else if (denyCnt < LIMIT) begin
            denyCntNext = denyCnt + 4'd1;
        end
    end

`ifdef DEFLECT_CNT_EN
    logic [2:0]  deflSum;
    logic [16:0] cntSum;

    always_comb begin
        deflSum = 3'd0;
        for (int r = 0; r < 5; r++) begin
            deflSum = deflSum + 3'(deflNext[r]);
        end
        cntSum = {1'b0, deflectCnt} + 17'(deflSum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deflectCnt <= 16'd0;
        end else begin
            deflectCnt <= cntSum[16] ? 16'hFFFF : cntSum[15:0];
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= 2'd0;
            allocOut   <= '0;
            allocValid <= '0;
            deflected  <= '0;
            injGnt     <= 1'b0;
            injState   <= INJ_IDLE;
            injStarve  <= 1'b0;
            denyCnt    <= 4'd0;
        end else begin
            allocOut   <= allocNext;
            allocValid <= validNext;
            deflected  <= deflNext;
            injGnt     <= injGntNext;
            denyCnt    <= denyCntNext;
            if (|validIn) begin
                ptr <= ptr + 2'd1;
            end

            // A grant or a dropped request always wins over reaching the limit.
            case (injState)
                INJ_IDLE: begin
                    if (injDenied) begin
                        injState  <= (denyCntNext == LIMIT) ? INJ_STARVED : INJ_WAIT;
                        injStarve <= (denyCntNext == LIMIT);
                    end
                end
                INJ_WAIT: begin
                    if (!injDenied) begin
                        injState  <= INJ_IDLE;
                        injStarve <= 1'b0;
                    end else if (denyCntNext == LIMIT) begin
                        injState  <= INJ_STARVED;
                        injStarve <= 1'b1;
                    end
                end
                INJ_STARVED: begin
                    if (!injDenied) begin
                        injState  <= INJ_IDLE;
                        injStarve <= 1'b0;
                    end
                end
                default: begin
                    injState  <= INJ_IDLE;
                    injStarve <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deflect_port_alloc.sv
// tb/tb_deflect_port_alloc.sv - self-checking bench for deflect_port_alloc against a rule-level model
module tb_deflect_port_alloc;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  validIn;
    logic [19:0] prodVecIn;
    logic        injReq;
    logic [4:0]  injProdVec;
    logic [24:0] allocOut;
    logic [4:0]  allocValid;
    logic [4:0]  deflected;
    logic        injGnt;
    logic        injStarve;
`ifdef DEFLECT_CNT_EN
    logic [15:0] deflectCnt;
`endif

    int nAssert = 0;
    int nFail   = 0;

    // Model state
    int mPtr = 0;
    int mRun = 0;
    int mCnt = 0;

    always #5 clk = ~clk;

    deflect_port_alloc #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .validIn    (validIn),
        .prodVecIn  (prodVecIn),
        .injReq     (injReq),
        .injProdVec (injProdVec),
        .allocOut   (allocOut),
        .allocValid (allocValid),
        .deflected  (deflected),
        .injGnt     (injGnt),
`ifdef DEFLECT_CNT_EN
        .injStarve  (injStarve),
        .deflectCnt (deflectCnt)
`else
        .injStarve  (injStarve)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serve channels in rotating order from mPtr, then injection, using the allocation rules.
    task automatic modelAlloc(input logic [3:0] v, input logic [19:0] pv, input logic ir,
                              input logic [4:0] ipv, output logic [24:0] ao,
                              output logic [4:0] av, output logic [4:0] df);
        bit used [5];
        int ch;
        int pick;
        ao = '0; av = '0; df = '0;
        for (int p = 0; p < 5; p++) used[p] = 0;
        for (int j = 0; j < 4; j++) begin
            ch = (mPtr + j) % 4;
            if (v[ch]) begin
                pick = -1;
                for (int p = 0; p < 5; p++)
                    if (pick < 0 && pv[5*ch+p] && !used[p]) pick = p;
                for (int p = 0; p < 4; p++)
                    if (pick < 0 && !used[p]) pick = p;
                used[pick] = 1;
                ao[5*ch+pick] = 1'b1;
                av[ch] = 1'b1;
                df[ch] = !pv[5*ch+pick];
            end
        end
        if (ir) begin
            pick = -1;
            for (int p = 0; p < 4; p++)
                if (pick < 0 && ipv[p] && !used[p]) pick = p;
            for (int p = 0; p < 4; p++)
                if (pick < 0 && !used[p]) pick = p;
            if (pick >= 0) begin
                ao[20+pick] = 1'b1;
                av[4] = 1'b1;
                df[4] = !ipv[pick];
            end
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [19:0] pv, input logic ir,
                        input logic [4:0] ipv);
        logic [24:0] eAo;
        logic [4:0]  eAv;
        logic [4:0]  eDf;
        validIn = v; prodVecIn = pv; injReq = ir; injProdVec = ipv;
        modelAlloc(v, pv, ir, ipv, eAo, eAv, eDf);
        @(posedge clk);
        #1;
        if (|v) mPtr = (mPtr + 1) % 4;
        if (!ir || eAv[4]) mRun = 0; else mRun++;
        mCnt = mCnt + $countones(eDf);
        if (mCnt > 65535) mCnt = 65535;
        check("allocOut", 32'(allocOut), 32'(eAo));
        check("allocValid", 32'(allocValid), 32'(eAv));
        check("deflected", 32'(deflected), 32'(eDf));
        check("injGnt", 32'(injGnt), 32'(eAv[4]));
        check("injStarve", 32'(injStarve), 32'(mRun >= LIMIT));
`ifdef DEFLECT_CNT_EN
        check("deflectCnt", 32'(deflectCnt), 32'(mCnt));
`endif
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_allocOut"}, 32'(allocOut), 32'd0);
        check({tag, "_allocValid"}, 32'(allocValid), 32'd0);
        check({tag, "_deflected"}, 32'(deflected), 32'd0);
        check({tag, "_injGnt"}, 32'(injGnt), 32'd0);
        check({tag, "_injStarve"}, 32'(injStarve), 32'd0);
    endtask

    initial begin
        logic [19:0] allOne;
        allOne = {4{5'b00001}};

        reset = 1'b1; validIn = '0; prodVecIn = '0; injReq = 1'b0; injProdVec = '0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;

        // Single productive flit on West, then ptr=1 shows up as ch1 served first.
        step(4'b0001, 20'b00010, 1'b0, 5'd0);
        step(4'b1111, allOne, 1'b0, 5'd0);

        // All four channels want port 0 with ptr back at 0; injection finds nothing.
        while (mPtr != 0) step(4'b0001, 20'b00001, 1'b0, 5'd0);
        step(4'b1111, allOne, 1'b1, 5'b00001);

        // Two Local requests: first served gets Local, second deflects.
        while (mPtr != 0) step(4'b0001, 20'b00001, 1'b0, 5'd0);
        step(4'b0101, {5'b0, 5'b10000, 5'b0, 5'b10000}, 1'b0, 5'd0);

        // Starvation build-up, then the first grant clears it.
        for (int i = 0; i < 12; i++) step(4'b1111, allOne, 1'b1, 5'b00010);
        step(4'b0000, '0, 1'b1, 5'b00010);
        step(4'b0000, '0, 1'b0, 5'b00000);

        // Random traffic; dense valid phases so starvation is exercised.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] v;
            v = (i % 50 < 20) ? 4'b1111 : 4'($urandom);
            step(v, 20'($urandom), ($urandom_range(0, 3) != 0), 5'($urandom));
        end

        // Asynchronous reset in the middle of a cycle.
        step(4'b1111, allOne, 1'b1, 5'b00001);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("asyncReset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        mPtr = 0; mRun = 0; mCnt = 0;
        step(4'b1111, allOne, 1'b0, 5'd0);
        for (int i = 0; i < 30; i++) step(4'($urandom), 20'($urandom), 1'($urandom), 5'($urandom));

`ifdef DEFLECT_CNT_EN
        for (int i = 0; i < 21846; i++) step(4'b1111, allOne, 1'b0, 5'd0);
        check("deflectCntSat", 32'(deflectCnt), 32'h0000FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
